// File: rtl/tpu_array_pkg.sv
// Shared types and helpers for the systolic array input path.
package tpu_array_pkg;

    // Skewer control states.
    typedef enum logic [1:0] {
        SKEW_IDLE   = 2'd0,
        SKEW_STREAM = 2'd1,
        SKEW_DRAIN  = 2'd2
    } skew_state_t;

    // Number of register stages on lane r: lane 0 is delayed one cycle,
    // each following lane one cycle more, which forms the diagonal wavefront.
    function automatic int skew_depth(input int r);
        return r + 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage shift register of WIDTH-bit words with
// asynchronous active-low reset. The output is the input delayed DEPTH cycles.
module skew_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_reg [DEPTH];

    // Shift one stage per cycle; reset clears every stage so nothing in flight survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/systolic_input_skewer.sv
// systolic_input_skewer: accepts one ROWS-wide vector per cycle, skews it
// diagonally onto the array data port (lane r delayed r+1 cycles), inserts
// zero bubbles on stall cycles and produces per-column result-valid tags.
// Optional build macro: SKEWER_PERF_COUNTERS_EN adds perf_vectors/perf_bubbles.
module systolic_input_skewer
    import tpu_array_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ROWS        = 8,
    parameter int COLUMNS     = ROWS,
    parameter int RESULT_BASE = ROWS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [DATA_WIDTH*ROWS-1:0] in_data,
    output logic [DATA_WIDTH*ROWS-1:0] out_data,
    output logic [ROWS-1:0]            out_row_vld,
    output logic [COLUMNS-1:0]         res_valid,
    output logic                       busy
`ifdef SKEWER_PERF_COUNTERS_EN
    ,
    output logic [31:0]                perf_vectors,
    output logic [31:0]                perf_bubbles
`endif
);

    // Tag stage k (1-based) holds the handshake delayed k cycles; column c
    // reads stage RESULT_BASE+c, so the deepest stage is RESULT_BASE+COLUMNS-1.
    localparam int TAG_DEPTH = RESULT_BASE + COLUMNS - 1;
    localparam int CNT_W     = $clog2(ROWS + 1);

    skew_state_t      state_reg;
    skew_state_t      state_next;
    logic [CNT_W-1:0] drain_cnt_reg;
    logic [CNT_W-1:0] drain_cnt_next;
    logic             in_ready_reg;
    logic             in_ready_next;
    logic             handshake;
    logic [TAG_DEPTH-1:0] tag_chain;

    assign handshake = in_valid && in_ready_reg;
    assign in_ready  = in_ready_reg;

    // Next-state logic: the last vector of a batch blocks input for ROWS cycles
    // so the final wavefront clears the array before a new batch starts.
    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            SKEW_IDLE, SKEW_STREAM: begin
                if (handshake) begin
                    if (in_last) begin
                        state_next     = SKEW_DRAIN;
                        drain_cnt_next = CNT_W'(ROWS);
                    end else begin
                        state_next = SKEW_STREAM;
                    end
                end
            end
            SKEW_DRAIN: begin
                drain_cnt_next = drain_cnt_reg - CNT_W'(1);
                if (drain_cnt_reg == CNT_W'(1)) begin
                    state_next = SKEW_IDLE;
                end
            end
            default: begin
                state_next     = SKEW_IDLE;
                drain_cnt_next = '0;
            end
        endcase
        // Ready is registered: it follows the state being entered, never in_valid directly.
        in_ready_next = (state_next != SKEW_DRAIN);
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SKEW_IDLE;
            drain_cnt_reg <= '0;
            in_ready_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            in_ready_reg  <= in_ready_next;
        end
    end

    // One delay line per lane carrying {valid, data}; non-handshake cycles
    // inject an all-zero word so a bubble travels exactly like a real vector.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] lane_data;
            logic [DATA_WIDTH:0]   lane_out;

            assign lane_data = handshake ? in_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

            skew_delay_line #(
                .WIDTH (DATA_WIDTH + 1),
                .DEPTH (skew_depth(gi))
            ) u_lane_delay (
                .clk   (clk),
                .rst_n (rst_n),
                .din   ({handshake, lane_data}),
                .dout  (lane_out)
            );

            assign out_row_vld[gi]                          = lane_out[DATA_WIDTH];
            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH]    = lane_out[DATA_WIDTH-1:0];
        end
    endgenerate

    // Result tag pipeline built from single-stage links so every stage is
    // visible for the in-flight check that drives busy.
    generate
        for (genvar gi = 0; gi < TAG_DEPTH; gi++) begin : g_tag
            logic tag_in;
            if (gi == 0) begin : g_head
                assign tag_in = handshake;
            end else begin : g_link
                assign tag_in = tag_chain[gi-1];
            end

            skew_delay_line #(
                .WIDTH (1),
                .DEPTH (1)
            ) u_tag_delay (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (tag_in),
                .dout  (tag_chain[gi])
            );
        end

        for (genvar gi = 0; gi < COLUMNS; gi++) begin : g_res
            assign res_valid[gi] = tag_chain[RESULT_BASE-1+gi];
        end
    endgenerate

    // Weights may only be reloaded once no vector or result tag is in flight.
    assign busy = (state_reg != SKEW_IDLE) || (|tag_chain);

`ifdef SKEWER_PERF_COUNTERS_EN
    logic [31:0] perf_vectors_reg;
    logic [31:0] perf_bubbles_reg;

    // Free-running wrap-around counters of accepted vectors and stall bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_vectors_reg <= '0;
            perf_bubbles_reg <= '0;
        end else begin
            if (handshake) begin
                perf_vectors_reg <= perf_vectors_reg + 32'd1;
            end
            if ((state_reg == SKEW_STREAM) && !handshake) begin
                perf_bubbles_reg <= perf_bubbles_reg + 32'd1;
            end
        end
    end

    assign perf_vectors = perf_vectors_reg;
    assign perf_bubbles = perf_bubbles_reg;
`endif

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Self-checking bench for systolic_input_skewer (ROWS=COLUMNS=4, DATA_WIDTH=8,
// RESULT_BASE=4). Expected lane words and result tags are queued when a vector
// is accepted by the bench's own handshake model and retired on their due cycle.
module tb_systolic_input_skewer;

    localparam int DW   = 8;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int RB   = 4;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_last  = 1'b0;
    logic [DW*ROWS-1:0] in_data = '0;
    logic            in_ready;
    logic [DW*ROWS-1:0] out_data;
    logic [ROWS-1:0] out_row_vld;
    logic [COLS-1:0] res_valid;
    logic            busy;
`ifdef SKEWER_PERF_COUNTERS_EN
    logic [31:0]     perf_vectors;
    logic [31:0]     perf_bubbles;
`endif

    systolic_input_skewer #(
        .DATA_WIDTH  (DW),
        .ROWS        (ROWS),
        .COLUMNS     (COLS),
        .RESULT_BASE (RB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .in_data      (in_data),
        .out_data     (out_data),
        .out_row_vld  (out_row_vld),
        .res_valid    (res_valid),
        .busy         (busy)
`ifdef SKEWER_PERF_COUNTERS_EN
        ,
        .perf_vectors (perf_vectors),
        .perf_bubbles (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         is_tag;
        int         idx;
        logic [7:0] data;
    } sb_entry_t;

    sb_entry_t sb[$];
    int cyc        = 0;
    int checks     = 0;
    int passes     = 0;
    int fails      = 0;
    int drain_left = 0;
    bit streaming  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Retire every scoreboard entry due this cycle and compare all outputs.
    task automatic check_outputs();
        logic [DW*ROWS-1:0] ed = '0;
        logic [ROWS-1:0]    ev = '0;
        logic [COLS-1:0]    er = '0;
        bit                 tags_pending = 1'b0;
        sb_entry_t          keep[$];
        foreach (sb[i]) begin
            if (sb[i].is_tag && sb[i].due >= cyc) tags_pending = 1'b1;
            if (sb[i].due == cyc) begin
                if (sb[i].is_tag) begin
                    er[sb[i].idx] = 1'b1;
                end else begin
                    ed[sb[i].idx*DW +: DW] = sb[i].data;
                    ev[sb[i].idx]          = 1'b1;
                end
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
        chk("out_data",    out_data,    ed);
        chk("out_row_vld", out_row_vld, ev);
        chk("res_valid",   res_valid,   er);
        chk("in_ready",    in_ready,    drain_left == 0);
        chk("busy",        busy,        streaming || (drain_left > 0) || tags_pending);
    endtask

    // Drive one cycle of stimulus, advance the model and check the next cycle.
    task automatic drive(input bit v, input bit l, input logic [DW*ROWS-1:0] d);
        bit acc;
        in_valid = v;
        in_last  = l;
        in_data  = d;
        acc = v && (drain_left == 0);
        if (acc) begin
            $display("cycle %0d: accept vector %08h last=%0d", cyc, d, l);
            for (int r = 0; r < ROWS; r++) sb.push_back('{cyc + 1 + r, 1'b0, r, d[r*DW +: DW]});
            for (int c = 0; c < COLS; c++) sb.push_back('{cyc + RB + c, 1'b1, c, 8'h00});
        end
        @(posedge clk);
        #1;
        if (drain_left > 0) drain_left--;
        if (acc) begin
            if (l) begin
                drain_left = ROWS;
                streaming  = 1'b0;
            end else begin
                streaming = 1'b1;
            end
        end
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_data"},  out_data,    '0);
        chk({tag, "_row_vld"},   out_row_vld, '0);
        chk({tag, "_res_valid"}, res_valid,   '0);
        chk({tag, "_busy"},      busy,        1'b0);
        chk({tag, "_in_ready"},  in_ready,    1'b1);
`ifdef SKEWER_PERF_COUNTERS_EN
        chk({tag, "_perf_vec"},  perf_vectors, 32'd0);
        chk({tag, "_perf_bub"},  perf_bubbles, 32'd0);
`endif
    endtask

    initial begin
        // Power-on reset, checked asynchronously before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_all_zero("por");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;

        // Stall: vectors on t0 and t2, bubble on t1 with junk data that must be masked.
        drive(1'b1, 1'b0, 32'h14131211);
        drive(1'b0, 1'b0, 32'hdeadbeef);
        drive(1'b1, 1'b1, 32'h24232221);
        idle(10);
`ifdef SKEWER_PERF_COUNTERS_EN
        chk("perf_vectors", perf_vectors, 32'd2);
        chk("perf_bubbles", perf_bubbles, 32'd1);
`endif

        // in_last without valid is ignored, then a single last vector.
        drive(1'b0, 1'b1, 32'hcafef00d);
        drive(1'b1, 1'b1, 32'h04030201);
        idle(10);

        // Four back-to-back vectors, last on the fourth.
        drive(1'b1, 1'b0, 32'h31323334);
        drive(1'b1, 1'b0, 32'h41424344);
        drive(1'b1, 1'b0, 32'h51525354);
        drive(1'b1, 1'b1, 32'h61626364);
        idle(12);

        // Valid held through DRAIN: the held vector enters on the first IDLE cycle.
        drive(1'b1, 1'b1, 32'h71727374);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 32'h81828384);
        idle(12);

        // Reset in the middle of a batch discards everything in flight.
        drive(1'b1, 1'b1, 32'h04030201);
        drive(1'b0, 1'b0, '0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        sb.delete();
        drain_left = 0;
        streaming  = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        check_outputs();
        idle(10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
